renesas_i2c_seq: RTL and testbench
==================================

RENESAS_I2C_SEQ -- requirements
Module: renesas_i2c_seq

Interface
REQ-001 Parameter POLL_GAP, default 16: idle cycles between consecutive status reads (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 1000000: poll-phase cycle limit (range 1..2^24-1).
REQ-003 sys_if_clk  in  1  single clock for all logic.
REQ-004 sys_if_rstn  in  1  reset; asynchronous assert, active-low.
REQ-005 seq_go  in  1  one-cycle request to run a transaction; ignored while seq_busy=1.
REQ-006 seq_busy  out  1  high from the cycle after an accepted seq_go until the cycle seq_done pulses.
REQ-007 seq_done  out  1  one-cycle completion pulse.
REQ-008 seq_err  out  1  sticky status error flag; cleared on the next accepted seq_go.
REQ-009 seq_timeout  out  1  sticky timeout flag; cleared on the next accepted seq_go.
REQ-010 hdr_data  out  128  captured headers: {H3,H2,H1,H0}, H0 in bits [31:0].
REQ-011 m_wen  out  1  register-bus write strobe, one cycle per write.
REQ-012 m_addr  out  32  register-bus address; registered.
REQ-013 m_wdata  out  32  register-bus write data; registered.
REQ-014 m_rdata  in  32  register-bus read data; combinational from m_addr.

Function
REQ-015 Register map: HEADER0..3 = 0x00/0x04/0x08/0x0C; STATUS = 0x10 (bit0 done, bit1 error); CONTROL = 0x14 (bit0 resetn, bit1 start, self-clearing).
REQ-016 FSM states: IDLE, HOLD, RELEASE, START, POLL_WAIT, POLL_RD, HDR_RD, DONE.
REQ-017 IDLE: on seq_go=1 -> HOLD; clear seq_err and seq_timeout.
REQ-018 HOLD: one write, CONTROL=0x0 -> RELEASE.
REQ-019 RELEASE: one write, CONTROL=0x1 -> START.
REQ-020 START: one write, CONTROL=0x3 -> POLL_WAIT; reload gap counter with POLL_GAP and zero the timeout counter.
REQ-021 POLL_WAIT: decrement gap counter; at 0 -> POLL_RD.
REQ-022 POLL_RD: m_addr=0x10 for exactly one cycle; sample m_rdata at the edge ending that cycle.
REQ-023 POLL_RD outcomes: bit1=1 -> set seq_err, go to DONE (error wins when bit0 and bit1 are both set); else bit0=1 -> HDR_RD; else -> POLL_WAIT with gap reloaded.
REQ-024 HDR_RD: read 0x00, 0x04, 0x08, 0x0C on consecutive cycles, one address per cycle; load each word into its hdr_data slice at the edge ending that cycle; after 0x0C -> DONE.
REQ-025 DONE: pulse seq_done for one cycle, deassert seq_busy in the same cycle -> IDLE.
REQ-026 Writes: m_wen=1 for exactly one cycle, with m_addr/m_wdata valid in that same cycle; m_wen=0 in every other state.
REQ-027 Latency without errors: seq_go to first status read = 4 + POLL_GAP cycles; done detected to seq_done = 5 cycles.
REQ-028 hdr_data holds its previous value on error or timeout paths and updates only in HDR_RD.
REQ-029 seq_go asserted in the same cycle as seq_done is ignored and is not queued.

Reset
REQ-030 Asynchronous reset -> IDLE with all outputs 0: seq_busy, seq_done, seq_err, seq_timeout, hdr_data, m_wen, m_addr, m_wdata; both counters 0.
REQ-031 Reset mid-transaction aborts immediately, and no further bus cycle is issued.

Configuration
REQ-032 Macro RENESAS_I2C_SEQ_TIMEOUT_EN defined: the timeout counter increments every cycle in POLL_WAIT/POLL_RD; on reaching TIMEOUT_CYC, set seq_timeout, write CONTROL=0x0 once, then go to DONE.
REQ-033 Macro undefined: there is no timeout counter, seq_timeout is tied to 0, and polling continues until a done or error status is read.

Structure
REQ-034 Shared package renesas_i2c_pkg holds the register address constants, the CONTROL/STATUS bit positions and the FSM state enum.
REQ-035 Single flat module with no sub-module; the counters are inline.

Verification
REQ-036 Status reads 0x1 on the 3rd poll, headers 0x11111111/0x22222222/0x33333333/0x44444444 -> writes 0x0, 0x1, 0x3 to 0x14; hdr_data = 0x44444444_33333333_22222222_11111111; one seq_done pulse.
REQ-037 Status reads 0x3 on the 1st poll -> seq_err=1, no header reads, hdr_data unchanged, seq_done pulses.
REQ-038 With the macro defined, TIMEOUT_CYC=100 and status stuck at 0x0 -> seq_timeout=1, CONTROL write 0x0, seq_done within 100+POLL_GAP+3 cycles.
REQ-039 seq_go pulsed while busy and in the seq_done cycle -> ignored; a single transaction runs.
REQ-040 sys_if_rstn low during POLL_WAIT -> outputs 0 asynchronously; a fresh seq_go after release completes normally.
REQ-041 POLL_GAP=1 with done already set -> first status read at cycle 5 after seq_go; seq_done at cycle 10.

Source files
------------

// File: rtl/renesas_i2c_pkg.sv
// Shared constants for the renesas_i2c_seq register-bus sequencer:
// register map, CONTROL/STATUS bit positions and the sequencer state enum.
package renesas_i2c_pkg;

  localparam logic [31:0] ADDR_HDR0    = 32'h0000_0000;
  localparam logic [31:0] ADDR_HDR3    = 32'h0000_000C;
  localparam logic [31:0] HDR_STRIDE   = 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0010;
  localparam logic [31:0] ADDR_CONTROL = 32'h0000_0014;

  localparam int CTRL_RESETN_BIT = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int STAT_DONE_BIT   = 0;
  localparam int STAT_ERR_BIT    = 1;

  // CONTROL values written by the three bring-up writes
  localparam logic [31:0] CTRL_HOLD    = 32'h0;
  localparam logic [31:0] CTRL_RELEASE = 32'h1 << CTRL_RESETN_BIT;
  localparam logic [31:0] CTRL_START   = CTRL_RELEASE | (32'h1 << CTRL_START_BIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE,
    ST_START,
    ST_POLL_WAIT,
    ST_POLL_RD,
    ST_HDR_RD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/renesas_i2c_seq_if.sv
// Sequencer handshake plus register-bus signals; master is the sequencer,
// slave is whatever drives seq_go and returns m_rdata.
interface renesas_i2c_seq_if;

  logic         seq_go;
  logic         seq_busy;
  logic         seq_done;
  logic         seq_err;
  logic         seq_timeout;
  logic [127:0] hdr_data;
  logic         m_wen;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;

  modport master (
    input  seq_go, m_rdata,
    output seq_busy, seq_done, seq_err, seq_timeout, hdr_data,
           m_wen, m_addr, m_wdata
  );

  modport slave (
    output seq_go, m_rdata,
    input  seq_busy, seq_done, seq_err, seq_timeout, hdr_data,
           m_wen, m_addr, m_wdata
  );

endinterface

// File: rtl/renesas_i2c_seq.sv
// Register-bus sequencer: reset/start the peripheral, poll STATUS, read four headers.
// Optional poll timeout enabled by defining RENESAS_I2C_SEQ_TIMEOUT_EN.
module renesas_i2c_seq
  import renesas_i2c_pkg::*;
#(
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic            sys_if_clk,
  input  logic            sys_if_rstn,
  renesas_i2c_seq_if.master bus
);

  state_t        r_state;
  state_t        w_stateNxt;
  logic [7:0]    r_gapCnt;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_wen;
  logic [31:0]   r_mAddr;
  logic [31:0]   r_mWdata;
  logic [127:0]  r_hdrData;
  logic          w_goAccept;
  logic          w_statDone;
  logic          w_statErr;
  logic          w_tmoHit;
  logic          w_timeout;
  logic          w_wen;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;

  assign w_goAccept = (r_state == ST_IDLE) && bus.seq_go;
  assign w_statDone = bus.m_rdata[STAT_DONE_BIT];
  assign w_statErr  = bus.m_rdata[STAT_ERR_BIT];

`ifdef RENESAS_I2C_SEQ_TIMEOUT_EN
  logic [23:0] r_tmoCnt;
  logic        r_timeout;

  assign w_tmoHit  = ((r_state == ST_POLL_WAIT) || (r_state == ST_POLL_RD)) &&
                     (r_tmoCnt == 24'(TIMEOUT_CYC - 1));
  assign w_timeout = r_timeout;

  // The counter only spans the poll phase; a hit reuses HOLD to park CONTROL at 0
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      r_tmoCnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_START) begin
        r_tmoCnt <= '0;
      end else if ((r_state == ST_POLL_WAIT) || (r_state == ST_POLL_RD)) begin
        r_tmoCnt <= r_tmoCnt + 24'd1;
      end
      if (w_goAccept) begin
        r_timeout <= 1'b0;
      end else if (w_tmoHit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  // A zero limit is not a legal configuration, so polling never gives up
  assign w_tmoHit  = (TIMEOUT_CYC == 0);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      ST_IDLE:      if (bus.seq_go) w_stateNxt = ST_HOLD;
      ST_HOLD:      w_stateNxt = w_timeout ? ST_DONE : ST_RELEASE;
      ST_RELEASE:   w_stateNxt = ST_START;
      ST_START:     w_stateNxt = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (w_tmoHit)            w_stateNxt = ST_HOLD;
        else if (r_gapCnt <= 8'd1) w_stateNxt = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        if (w_tmoHit)        w_stateNxt = ST_HOLD;
        else if (w_statErr)  w_stateNxt = ST_DONE;
        else if (w_statDone) w_stateNxt = ST_HDR_RD;
        else                 w_stateNxt = ST_POLL_WAIT;
      end
      ST_HDR_RD:    if (r_mAddr == ADDR_HDR3) w_stateNxt = ST_DONE;
      ST_DONE:      w_stateNxt = ST_IDLE;
      default:      w_stateNxt = ST_IDLE;
    endcase
  end

  // Bus values for the coming cycle, so the registered bus lines up with the state
  always_comb begin
    w_wen   = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (w_stateNxt)
      ST_HOLD:    begin w_wen = 1'b1; w_addr = ADDR_CONTROL; w_wdata = CTRL_HOLD;    end
      ST_RELEASE: begin w_wen = 1'b1; w_addr = ADDR_CONTROL; w_wdata = CTRL_RELEASE; end
      ST_START:   begin w_wen = 1'b1; w_addr = ADDR_CONTROL; w_wdata = CTRL_START;   end
      ST_POLL_RD: w_addr = ADDR_STATUS;
      ST_HDR_RD:  w_addr = (r_state == ST_HDR_RD) ? (r_mAddr + HDR_STRIDE) : ADDR_HDR0;
      default:    ;
    endcase
  end

  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      r_gapCnt <= '0;
    end else if ((r_state == ST_START) || (r_state == ST_POLL_RD)) begin
      r_gapCnt <= 8'(POLL_GAP);
    end else if ((r_state == ST_POLL_WAIT) && (r_gapCnt != 8'd0)) begin
      r_gapCnt <= r_gapCnt - 8'd1;
    end
  end

  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      r_wen     <= 1'b0;
      r_mAddr   <= '0;
      r_mWdata  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_hdrData <= '0;
    end else begin
      r_wen    <= w_wen;
      r_mAddr  <= w_addr;
      r_mWdata <= w_wdata;
      r_busy   <= (w_stateNxt != ST_IDLE) && (w_stateNxt != ST_DONE);
      r_done   <= (w_stateNxt == ST_DONE);
      if (w_goAccept) begin
        r_err <= 1'b0;
      end else if ((r_state == ST_POLL_RD) && !w_tmoHit && w_statErr) begin
        r_err <= 1'b1;
      end
      // The header address itself selects which 32-bit slice is loaded
      if (r_state == ST_HDR_RD) begin
        r_hdrData[{r_mAddr[3:2], 5'd0} +: 32] <= bus.m_rdata;
      end
    end
  end

  assign bus.seq_busy    = r_busy;
  assign bus.seq_done    = r_done;
  assign bus.seq_err     = r_err;
  assign bus.seq_timeout = w_timeout;
  assign bus.hdr_data    = r_hdrData;
  assign bus.m_wen       = r_wen;
  assign bus.m_addr      = r_mAddr;
  assign bus.m_wdata     = r_mWdata;

endmodule

// File: tb/tb_renesas_i2c_seq.sv
// Randomized bench for renesas_i2c_seq with a transaction-level expectation model.
// Define RENESAS_I2C_SEQ_TIMEOUT_EN to also exercise the poll timeout.
module tb_renesas_i2c_seq;

  localparam int TMO = 100;
`ifdef RENESAS_I2C_SEQ_TIMEOUT_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 1;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  renesas_i2c_seq_if bus();

  renesas_i2c_seq #(.POLL_GAP(GAP), .TIMEOUT_CYC(TMO)) dut (
    .sys_if_clk  (clk),
    .sys_if_rstn (rstn),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  logic [31:0]  hdrMem [4];
  logic [31:0]  statusMem [256];
  logic [7:0]   pollCnt = 8'd0;
  logic [31:0]  slaveRdata;
  logic [127:0] expHdr;

  int          wrCount = 0;
  int          stCount = 0;
  int          doneCount = 0;
  int          busyCount = 0;
  logic [31:0] wrAddr [1024];
  logic [31:0] wrData [1024];
  int          wrCyc [1024];
  int          stCyc [1024];
  int          doneCyc [1024];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Peripheral model: headers and a scripted sequence of STATUS values
  always_comb begin
    slaveRdata = 32'h0;
    case (bus.m_addr)
      32'h00:  slaveRdata = hdrMem[0];
      32'h04:  slaveRdata = hdrMem[1];
      32'h08:  slaveRdata = hdrMem[2];
      32'h0C:  slaveRdata = hdrMem[3];
      32'h10:  slaveRdata = statusMem[pollCnt];
      default: ;
    endcase
  end
  assign bus.m_rdata = slaveRdata;

  always @(posedge clk) if (bus.m_addr == 32'h10) pollCnt <= pollCnt + 8'd1;

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.m_wen) begin
      wrAddr[wrCount % 1024] = bus.m_addr;
      wrData[wrCount % 1024] = bus.m_wdata;
      wrCyc[wrCount % 1024]  = cycleCnt;
      wrCount++;
    end
    if (bus.m_addr == 32'h10) begin
      stCyc[stCount % 1024] = cycleCnt;
      stCount++;
    end
    if (bus.seq_done) begin
      doneCyc[doneCount % 1024] = cycleCnt;
      doneCount++;
    end
    if (bus.seq_busy) busyCount++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: nZero not-ready polls, then a final status carrying fin in bits [1:0]
  task automatic applyStimulus(input int nZero, input logic [1:0] fin, input bit extraGo,
                               input bit fixedHdr);
    int goCycle, expFirst, expLast, expDone, obsDone, obsFirst, obsLast;
    int wrBase, stBase, doneBase, busyBase;
    logic [31:0] expCtl [3];
    bit isErr;
    expCtl = '{32'h0, 32'h1, 32'h3};
    isErr  = fin[1];
    for (int i = 0; i < 4; i++) hdrMem[i] = fixedHdr ? 32'h1111_1111 * (i + 1) : $urandom;
    for (int j = 0; j < nZero; j++) statusMem[8'(pollCnt + 8'(j))] = $urandom & 32'hFFFF_FFFC;
    statusMem[8'(pollCnt + 8'(nZero))] = ($urandom & 32'hFFFF_FFFC) | {30'h0, fin};
    expFirst = 4 + GAP;
    expLast  = expFirst + nZero * (GAP + 1);
    expDone  = expLast + (isErr ? 1 : 5);

    @(posedge clk); #1;
    goCycle  = cycleCnt;
    wrBase   = wrCount;
    stBase   = stCount;
    doneBase = doneCount;
    busyBase = busyCount;
    bus.seq_go = 1'b1;
    for (int k = 1; k <= expDone + 6; k++) begin
      @(posedge clk); #1;
      bus.seq_go = extraGo && ((k == 2) || (k == expDone));
      if (k == 1) checkOutput("busy_after_go", bus.seq_busy, 1'b1);
    end
    bus.seq_go = 1'b0;
    if (!isErr) expHdr = {hdrMem[3], hdrMem[2], hdrMem[1], hdrMem[0]};

    obsDone  = (doneCount > doneBase) ? doneCyc[doneBase % 1024] - goCycle : -1;
    obsFirst = (stCount > stBase) ? stCyc[stBase % 1024] - goCycle : -1;
    obsLast  = (stCount > stBase) ? stCyc[(stCount - 1) % 1024] - goCycle : -1;
    checkOutput("done_pulses", doneCount - doneBase, 1);
    checkOutput("done_cycle", obsDone, expDone);
    checkOutput("busy_cycles", busyCount - busyBase, expDone - 1);
    checkOutput("status_reads", stCount - stBase, nZero + 1);
    checkOutput("first_status_cycle", obsFirst, expFirst);
    checkOutput("last_status_cycle", obsLast, expLast);
    checkOutput("write_count", wrCount - wrBase, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ctl_write", {wrAddr[(wrBase + i) % 1024], wrData[(wrBase + i) % 1024]},
                  {32'h14, expCtl[i]});
      checkOutput("ctl_write_cycle", wrCyc[(wrBase + i) % 1024] - goCycle, i + 1);
    end
    checkOutput("err_flag", bus.seq_err, isErr);
    checkOutput("timeout_flag", bus.seq_timeout, 1'b0);
    checkOutput("busy_idle", bus.seq_busy, 1'b0);
    checkOutput("hdr_data", bus.hdr_data, expHdr);
  endtask

`ifdef RENESAS_I2C_SEQ_TIMEOUT_EN
  task automatic applyTimeout();
    int goCycle, obsDone, wrBase, doneBase;
    for (int j = 0; j < 64; j++) statusMem[8'(pollCnt + 8'(j))] = $urandom & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    goCycle  = cycleCnt;
    wrBase   = wrCount;
    doneBase = doneCount;
    bus.seq_go = 1'b1;
    for (int k = 1; k <= TMO + GAP + 3 + 6; k++) begin
      @(posedge clk); #1;
      bus.seq_go = 1'b0;
    end
    obsDone = (doneCount > doneBase) ? doneCyc[doneBase % 1024] - goCycle : -1;
    checkOutput("tmo_done_pulses", doneCount - doneBase, 1);
    checkOutput("tmo_done_in_time", (obsDone > 0) && (obsDone <= TMO + GAP + 3), 1'b1);
    checkOutput("tmo_flag", bus.seq_timeout, 1'b1);
    checkOutput("tmo_err_flag", bus.seq_err, 1'b0);
    checkOutput("tmo_write_count", wrCount - wrBase, 4);
    checkOutput("tmo_ctl_write", {wrAddr[(wrCount - 1) % 1024], wrData[(wrCount - 1) % 1024]},
                {32'h14, 32'h0});
    checkOutput("tmo_hdr_data", bus.hdr_data, expHdr);
  endtask
`endif

  initial begin
    int wrBase, stBase, goCycle;
    rstn = 1'b0;
    bus.seq_go = 1'b0;
    expHdr = '0;
    for (int i = 0; i < 256; i++) statusMem[i] = 32'h0;
    for (int i = 0; i < 4; i++) hdrMem[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {bus.seq_busy, bus.seq_done, bus.seq_err, bus.seq_timeout,
                                  bus.m_wen, bus.m_addr, bus.m_wdata}, '0);
    checkOutput("reset_hdr", bus.hdr_data, '0);
    @(negedge clk) rstn = 1'b1;

    applyStimulus(2, 2'b01, 1'b0, 1'b1);
    applyStimulus(0, 2'b11, 1'b0, 1'b0);
    applyStimulus(0, 2'b01, 1'b1, 1'b0);
    applyStimulus(1, 2'b10, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      applyStimulus(int'($urandom_range(0, 6)), 2'($urandom_range(1, 3)),
                    1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef RENESAS_I2C_SEQ_TIMEOUT_EN
    applyTimeout();
    applyStimulus(1, 2'b01, 1'b0, 1'b0);
`endif

    // Abort mid-poll: reset lands while the sequencer waits between status reads
    for (int j = 0; j < 16; j++) statusMem[8'(pollCnt + 8'(j))] = 32'h0;
    @(posedge clk); #1;
    goCycle = cycleCnt;
    bus.seq_go = 1'b1;
    for (int k = 1; k <= 4 + GAP + 1; k++) begin
      @(posedge clk); #1;
      bus.seq_go = 1'b0;
    end
    checkOutput("busy_before_rst", bus.seq_busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_async_outputs", {bus.seq_busy, bus.seq_done, bus.seq_err, bus.seq_timeout,
                                      bus.m_wen, bus.m_addr, bus.m_wdata}, '0);
    checkOutput("rst_async_hdr", bus.hdr_data, '0);
    wrBase = wrCount;
    stBase = stCount;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_no_bus", (wrCount - wrBase) + (stCount - stBase), 0);
    @(negedge clk) rstn = 1'b1;
    expHdr = '0;
    applyStimulus(1, 2'b01, 1'b0, 1'b0);

    $display("[TB] cycles run since go of abort test: %0d", cycleCnt - goCycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
